mux2_vector_sequencer: RTL

- Clocked stimulus generator and checker that sits directly upstream of the combinational 2:1 MUX stage (inputs a, b, c; output y), with c as the select.
- Steps the MUX inputs through all 8 combinations {a,b,c} = 000..111, holding each for a programmable dwell time.
- Samples the MUX output at the end of each dwell and compares it against expected y = c ? b : a.
- Reports an error count and a pass/fail flag. Replaces free-running bench stimulus with a synthesizable, self-checking on-chip sequencer.

---
 rtl/mux2_vector_sequencer_if.sv | 33 +++
 rtl/mux2_vector_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mux2_vector_sequencer_if.sv
`default_nettype none
// ============================================================================
// mux2_vector_sequencer_if
// Control, status and MUX-stimulus signals for the 2:1 MUX sweep sequencer.
// Rev 1.0 - initial release
// ============================================================================
interface mux2_vector_sequencer_if;
  logic       start;
  logic       loop;
  logic       abort;
  logic       y_in;
  logic       a;
  logic       b;
  logic       c;
  logic [2:0] vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;

  // Sequencer side: drives MUX inputs and status, observes control and y_in
  modport master (
    input  start, loop, abort, y_in,
    output a, b, c, vec_idx, busy, done, pass, err_cnt
  );

  // Environment side: drives control and the MUX result, observes status
  modport slave (
    output start, loop, abort, y_in,
    input  a, b, c, vec_idx, busy, done, pass, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mux2_vector_sequencer.sv
`default_nettype none
// ============================================================================
// mux2_vector_sequencer
// Steps a 2:1 MUX through all eight {a,b,c} vectors, holds each for DWELL
// cycles, samples y_in at the end of each dwell against c ? b : a, and
// reports a saturating mismatch count and a per-sweep pass flag.
// Rev 1.0 - initial release
// ============================================================================
module mux2_vector_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  mux2_vector_sequencer_if.master bus
);

  localparam logic [1:0]       S_IDLE = 2'd0;
  localparam logic [1:0]       S_RUN  = 2'd1;
  localparam logic [1:0]       S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DWELL - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_vec;
  logic [3:0]       r_err;
  logic             r_sweep_err;
  logic             r_pass;
  logic             r_done;
  logic             r_busy;
  logic             w_done_nxt;
  logic             w_busy_nxt;

  // End of a dwell: the currently driven vector is judged on this cycle
  wire w_tick      = (r_state == S_RUN) && (r_cnt == c_LAST);
  wire w_expected  = r_vec[0] ? r_vec[1] : r_vec[2];
  wire w_mismatch  = w_tick && (bus.y_in != w_expected);
  wire w_sweep_end = w_tick && (r_vec == 3'd7);
  // Launch a fresh sweep; start is only honoured outside RUN and loses to abort
  wire w_launch    = (r_state != S_RUN) && bus.start && !bus.abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; abort overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
        S_RUN:   if (w_sweep_end && !bus.loop) w_state_nxt = S_DONE;
        S_DONE:  if (bus.start) w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values of the status flags: done pulses on a looping sweep end and
  // is held while parked in DONE until a new start or abort
  always_comb begin
    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = 1'b0;
    if (!bus.abort) begin
      w_done_nxt = w_sweep_end || ((r_state == S_DONE) && !bus.start);
    end
  end

  // Vector, dwell counter, error accounting and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_vec       <= 3'd0;
      r_err       <= 4'd0;
      r_sweep_err <= 1'b0;
      r_pass      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_busy <= w_busy_nxt;
      if (bus.abort) begin
        // err_cnt and pass deliberately survive an abort
        r_cnt       <= '0;
        r_vec       <= 3'd0;
        r_sweep_err <= 1'b0;
      end else if (w_launch) begin
        r_cnt       <= '0;
        r_vec       <= 3'd0;
        r_err       <= 4'd0;
        r_pass      <= 1'b0;
        r_sweep_err <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (w_tick) begin
          r_cnt <= '0;
          if (w_mismatch && (r_err != 4'hF)) r_err <= r_err + 4'd1;
          if (r_vec == 3'd7) begin
            // pass covers only the sweep just finished, not the running total
            r_pass      <= !(r_sweep_err || w_mismatch);
            r_sweep_err <= 1'b0;
            if (bus.loop) r_vec <= 3'd0;
          end else begin
            r_vec       <= r_vec + 3'd1;
            r_sweep_err <= r_sweep_err || w_mismatch;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.a       = r_vec[2];
  assign bus.b       = r_vec[1];
  assign bus.c       = r_vec[0];
  assign bus.vec_idx = r_vec;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.pass    = r_pass;
  assign bus.err_cnt = r_err;

endmodule
`default_nettype wire
